seg7_result_scan: RTL

//  Downstream display stage for the sequential 16-bit divider.
//  - Captures the divider result when its done output rises.
//  - Shows the result as 4 hex digits on a time-multiplexed 4-digit 7-segment display.
//  - Owns the refresh counter, digit rotation, hex->segment decode and the pre-result "----" display.
//  - Sits between the divider core and the board-level top.

---
 rtl/seg7_result_scan.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_result_scan.sv
// Captures the divider result on the rising edge of done and scans it as 4 hex digits
// onto a multiplexed active-low 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_result_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [DW-1:0] result,
  output logic [6:0]    seg,
  output logic [3:0]    an,
  output logic          valid
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = 2;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic             done_d;
  logic [DW-1:0]    value;
  logic [CNT_W-1:0] scan_cnt;
  logic [DIG_W-1:0] dig;

  logic             cap_c;
  logic             wrap_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic [6:0]       seg_nxt_c;
  logic [3:0]       an_nxt_c;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Rising-edge detect on done and refresh-period wrap
  always_comb begin
    cap_c  = done & ~done_d;
    wrap_c = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  end

  // Capture and scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d   <= 1'b0;
      value    <= '0;
      valid    <= 1'b0;
      scan_cnt <= '0;
      dig      <= '0;
    end else begin
      done_d <= done;
      if (cap_c) begin
        value <= result;
        valid <= 1'b1;
      end
      if (wrap_c) begin
        scan_cnt <= '0;
        dig      <= dig + DIG_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

  // Nibble select for the active digit
  always_comb begin
    nib_c = value[3:0];
    case (dig)
      2'd0:    nib_c = value[3:0];
      2'd1:    nib_c = value[7:4];
      2'd2:    nib_c = value[11:8];
      default: nib_c = value[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every more significant nibble are zero; digit 0 never is
  always_comb begin
    blank_c = 1'b0;
    case (dig)
      2'd0:    blank_c = 1'b0;
      2'd1:    blank_c = (value[15:4] == 12'd0);
      2'd2:    blank_c = (value[15:8] == 8'd0);
      default: blank_c = (value[15:12] == 4'd0);
    endcase
  end
`else
  always_comb begin
    blank_c = 1'b0;
  end
`endif

  // Next display pattern from the currently registered state
  always_comb begin
    an_nxt_c  = ~(4'b0001 << dig);
    seg_nxt_c = SEG_DASH;
    if (valid) begin
      seg_nxt_c = blank_c ? SEG_OFF : hex7(nib_c);
    end
  end

  // Display output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      an  <= 4'b1111;
    end else begin
      seg <= seg_nxt_c;
      an  <= an_nxt_c;
    end
  end

endmodule
